// File: rtl/hazard3_ahbl_arb_pkg.sv
// hazard3_ahbl_arb_pkg: shared owner encoding, transfer types and address-phase control layout
package hazard3_ahbl_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef struct packed {
      logic [1:0] htrans;
      logic       hwrite;
      logic [2:0] hsize;
      logic [2:0] hburst;
      logic [3:0] hprot;
      logic       hmastlock;
      logic       hexcl;
   } ctrl_t;

   localparam int W_CTRL = $bits(ctrl_t);

endpackage

// File: rtl/hazard3_ahbl_arbiter_2port_if.sv
// hazard3_ahbl_arbiter_2port_if: AHB-Lite request/response bundle with master and slave views
interface hazard3_ahbl_arbiter_2port_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic [W_ADDR-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic              hexcl;
   logic              hmastlock;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic [W_DATA-1:0] hwdata;
   logic              hready;
   logic              hresp;
   logic              hexokay;
   logic [W_DATA-1:0] hrdata;

   modport master (
      output haddr, htrans, hwrite, hexcl, hmastlock, hsize, hburst, hprot, hwdata,
      input  hready, hresp, hexokay, hrdata
   );

   modport slave (
      input  haddr, htrans, hwrite, hexcl, hmastlock, hsize, hburst, hprot, hwdata,
      output hready, hresp, hexokay, hrdata
   );
endinterface

// File: rtl/hazard3_ahbl_req_buf.sv
// hazard3_ahbl_req_buf: single-entry address-phase holding register with load/clear
module hazard3_ahbl_req_buf
   import hazard3_ahbl_arb_pkg::*;
#(
   parameter int W_ADDR = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clr,
   input  logic [W_ADDR-1:0] addr_d,
   input  ctrl_t             ctrl_d,
   output logic              vld,
   output logic [W_ADDR-1:0] addr_q,
   output ctrl_t             ctrl_q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= 1'b0;
         addr_q <= '0;
         ctrl_q <= '0;
      end else if (load) begin
         vld    <= 1'b1;
         addr_q <= addr_d;
         ctrl_q <= ctrl_d;
      end else if (clr) begin
         vld    <= 1'b0;
      end
   end
endmodule

// File: rtl/hazard3_ahbl_arbiter_2port.sv
// hazard3_ahbl_arbiter_2port: fixed-priority 2:1 AHB-Lite arbiter with hmastlock and
// one buffered address phase per master so no accepted request is ever dropped.
module hazard3_ahbl_arbiter_2port
   import hazard3_ahbl_arb_pkg::*;
#(
   parameter int W_ADDR     = 32,
   parameter int W_DATA     = 32,
   parameter int PRIORITY_D = 1
) (
   input logic                          clk,
   input logic                          rst_n,
   hazard3_ahbl_arbiter_2port_if.slave  i,
   hazard3_ahbl_arbiter_2port_if.slave  d,
   hazard3_ahbl_arbiter_2port_if.master s
);
   owner_t            dph_owner, lock_owner, gnt;
   ctrl_t             live_ctrl_i, live_ctrl_d, buf_ctrl_i, buf_ctrl_d;
   ctrl_t             eff_ctrl_i, eff_ctrl_d, sel_ctrl;
   logic [W_ADDR-1:0] buf_addr_i, buf_addr_d, eff_addr_i, eff_addr_d;
   logic              buf_vld_i, buf_vld_d, hready_i, hready_d;
   logic              live_i, live_d, want_i, want_d;

   assign live_ctrl_i = '{i.htrans, i.hwrite, i.hsize, i.hburst, i.hprot, i.hmastlock, i.hexcl};
   assign live_ctrl_d = '{d.htrans, d.hwrite, d.hsize, d.hburst, d.hprot, d.hmastlock, d.hexcl};

   assign hready_i = dph_owner == OWN_I ? s.hready : !buf_vld_i;
   assign hready_d = dph_owner == OWN_D ? s.hready : !buf_vld_d;
   assign i.hready = hready_i;
   assign d.hready = hready_d;

   assign live_i = hready_i && i.htrans[1];
   assign live_d = hready_d && d.htrans[1];

   assign eff_addr_i = buf_vld_i ? buf_addr_i : i.haddr;
   assign eff_addr_d = buf_vld_d ? buf_addr_d : d.haddr;
   assign eff_ctrl_i = buf_vld_i ? buf_ctrl_i : live_ctrl_i;
   assign eff_ctrl_d = buf_vld_d ? buf_ctrl_d : live_ctrl_d;

   // A held lock excludes the other master entirely, even if the owner goes idle this cycle.
   assign want_i = (buf_vld_i || live_i) && lock_owner != OWN_D;
   assign want_d = (buf_vld_d || live_d) && lock_owner != OWN_I;

   assign gnt = !s.hready                               ? OWN_NONE :
                want_d && (PRIORITY_D != 0 || !want_i) ? OWN_D    :
                want_i                                  ? OWN_I    : OWN_NONE;

   assign s.haddr  = gnt == OWN_D ? eff_addr_d : gnt == OWN_I ? eff_addr_i : '0;
   assign sel_ctrl = gnt == OWN_D ? eff_ctrl_d : gnt == OWN_I ? eff_ctrl_i : '0;
   assign {s.htrans, s.hwrite, s.hsize, s.hburst, s.hprot, s.hmastlock, s.hexcl} = sel_ctrl;

   assign s.hwdata = dph_owner == OWN_I ? i.hwdata : dph_owner == OWN_D ? d.hwdata : {W_DATA{1'b0}};

   assign i.hresp   = dph_owner == OWN_I && s.hresp;
   assign d.hresp   = dph_owner == OWN_D && s.hresp;
   assign i.hexokay = dph_owner == OWN_I && s.hexokay;
   assign d.hexokay = dph_owner == OWN_D && s.hexokay;
   assign i.hrdata  = dph_owner == OWN_I ? s.hrdata : {W_DATA{1'b0}};
   assign d.hrdata  = dph_owner == OWN_D ? s.hrdata : {W_DATA{1'b0}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_owner  <= OWN_NONE;
         lock_owner <= OWN_NONE;
      end else if (s.hready) begin
         dph_owner  <= gnt;
         lock_owner <= sel_ctrl.hmastlock ? gnt : OWN_NONE;
      end
   end

   hazard3_ahbl_req_buf #(.W_ADDR(W_ADDR)) u_buf_i (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (live_i && gnt != OWN_I),
      .clr    (gnt == OWN_I),
      .addr_d (i.haddr),
      .ctrl_d (live_ctrl_i),
      .vld    (buf_vld_i),
      .addr_q (buf_addr_i),
      .ctrl_q (buf_ctrl_i)
   );

   hazard3_ahbl_req_buf #(.W_ADDR(W_ADDR)) u_buf_d (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (live_d && gnt != OWN_D),
      .clr    (gnt == OWN_D),
      .addr_d (d.haddr),
      .ctrl_d (live_ctrl_d),
      .vld    (buf_vld_d),
      .addr_q (buf_addr_d),
      .ctrl_q (buf_ctrl_d)
   );
endmodule

// File: tb/tb_hazard3_ahbl_arbiter_2port.sv
// tb_hazard3_ahbl_arbiter_2port: directed scenarios plus random traffic against a
// queue-based model of accepted-but-unforwarded requests per master.
module tb_hazard3_ahbl_arbiter_2port;
   import hazard3_ahbl_arb_pkg::*;

   localparam int PRI_D = 1;

   typedef struct packed {
      logic [31:0] addr;
      ctrl_t       c;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard3_ahbl_arbiter_2port_if #(.W_ADDR(32), .W_DATA(32)) i_bus ();
   hazard3_ahbl_arbiter_2port_if #(.W_ADDR(32), .W_DATA(32)) d_bus ();
   hazard3_ahbl_arbiter_2port_if #(.W_ADDR(32), .W_DATA(32)) s_bus ();

   hazard3_ahbl_arbiter_2port #(.W_ADDR(32), .W_DATA(32), .PRIORITY_D(PRI_D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i     (i_bus),
      .d     (d_bus),
      .s     (s_bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   req_t        mi [2];
   logic [31:0] wd [2];
   logic        sh_ready, sh_resp, sh_exokay;
   logic [31:0] sh_rdata;
   req_t        pq [2][$];
   int          own = 0;
   int          lk = 0;
   int          win;
   logic        hr [2];
   logic        live [2];
   logic        has [2];
   req_t        eff [2];
   req_t        exp_s;
   int          err = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      mi[0] = '0; mi[1] = '0; wd[0] = '0; wd[1] = '0;
      sh_ready = 1'b1; sh_resp = 1'b0; sh_exokay = 1'b0; sh_rdata = '0;
   endtask

   task automatic mreq(int m, logic [31:0] a, logic wr, logic lock);
      mi[m].addr = a;
      mi[m].c = '{htrans: HTRANS_NONSEQ, hwrite: wr, hsize: 3'd2, hburst: 3'd0,
                  hprot: 4'h3, hmastlock: lock, hexcl: 1'b0};
   endtask

   function automatic req_t rnd_req();
      req_t r;
      r.addr        = $urandom & 32'hffff_fffc;
      r.c.htrans    = ($urandom_range(0, 2) == 0) ? HTRANS_IDLE : {1'b1, 1'($urandom_range(0, 1))};
      r.c.hwrite    = 1'($urandom_range(0, 1));
      r.c.hsize     = 3'($urandom_range(0, 2));
      r.c.hburst    = 3'($urandom_range(0, 7));
      r.c.hprot     = 4'($urandom_range(0, 15));
      r.c.hmastlock = $urandom_range(0, 5) == 0;
      r.c.hexcl     = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic drive();
      i_bus.haddr = mi[0].addr;
      {i_bus.htrans, i_bus.hwrite, i_bus.hsize, i_bus.hburst, i_bus.hprot, i_bus.hmastlock, i_bus.hexcl} = mi[0].c;
      i_bus.hwdata = wd[0];
      d_bus.haddr = mi[1].addr;
      {d_bus.htrans, d_bus.hwrite, d_bus.hsize, d_bus.hburst, d_bus.hprot, d_bus.hmastlock, d_bus.hexcl} = mi[1].c;
      d_bus.hwdata = wd[1];
      s_bus.hready = sh_ready;
      s_bus.hresp = sh_resp;
      s_bus.hexokay = sh_exokay;
      s_bus.hrdata = sh_rdata;
   endtask

   // Model view: a master stalls only while its own data phase waits or while it has an
   // accepted request not yet forwarded; the slave always sees the winner's oldest request.
   task automatic eval();
      drive();
      #2;
      for (int m = 0; m < 2; m++) begin
         hr[m]   = (own == m + 1) ? sh_ready : (pq[m].size() == 0);
         live[m] = hr[m] && mi[m].c.htrans[1];
         has[m]  = pq[m].size() != 0 || live[m];
         eff[m]  = pq[m].size() != 0 ? pq[m][0] : mi[m];
      end
      win = -1;
      if (sh_ready) begin
         if (lk != 0) begin
            if (has[lk-1]) win = lk - 1;
         end else if (has[0] && has[1]) win = PRI_D != 0 ? 1 : 0;
         else if (has[1]) win = 1;
         else if (has[0]) win = 0;
      end
      exp_s = win >= 0 ? eff[win] : '0;
      chk("i_hready", i_bus.hready, hr[0]);
      chk("d_hready", d_bus.hready, hr[1]);
      chk("s_haddr", s_bus.haddr, exp_s.addr);
      chk("s_ctrl", {s_bus.htrans, s_bus.hwrite, s_bus.hsize, s_bus.hburst, s_bus.hprot,
                     s_bus.hmastlock, s_bus.hexcl}, exp_s.c);
      chk("s_hwdata", s_bus.hwdata, own == 1 ? wd[0] : own == 2 ? wd[1] : 32'h0);
      chk("i_hresp", i_bus.hresp, own == 1 && sh_resp);
      chk("d_hresp", d_bus.hresp, own == 2 && sh_resp);
      chk("i_hexokay", i_bus.hexokay, own == 1 && sh_exokay);
      chk("d_hexokay", d_bus.hexokay, own == 2 && sh_exokay);
      chk("i_hrdata", i_bus.hrdata, own == 1 ? sh_rdata : 32'h0);
      chk("d_hrdata", d_bus.hrdata, own == 2 ? sh_rdata : 32'h0);
   endtask

   task automatic adv();
      @(posedge clk);
      if (sh_ready) begin
         own = win + 1;
         lk = (win >= 0 && eff[win].c.hmastlock) ? win + 1 : 0;
      end
      for (int m = 0; m < 2; m++) begin
         if (live[m]) pq[m].push_back(mi[m]);
         if (win == m) void'(pq[m].pop_front());
      end
      #1;
   endtask

   task automatic model_reset();
      own = 0; lk = 0;
      pq[0].delete(); pq[1].delete();
   endtask

   initial begin
      idle();
      drive();
      #2;
      chk("rst_i_hready", i_bus.hready, 1'b1);
      chk("rst_d_hready", d_bus.hready, 1'b1);
      chk("rst_s_htrans", s_bus.htrans, HTRANS_IDLE);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // lone i read
      mreq(0, 32'h100, 1'b0, 1'b0);
      eval();
      chk("tp1_htrans", s_bus.htrans, 2'b10);
      chk("tp1_haddr", s_bus.haddr, 32'h100);
      adv();
      mi[0] = '0; sh_rdata = 32'h1234_5678;
      eval();
      chk("tp1_rdata", i_bus.hrdata, 32'h1234_5678);
      chk("tp1_hready", i_bus.hready, 1'b1);
      adv();

      // simultaneous requests, d has priority
      mreq(0, 32'h200, 1'b0, 1'b0); mreq(1, 32'h8000_0000, 1'b0, 1'b0);
      eval();
      chk("tp2_first", s_bus.haddr, 32'h8000_0000);
      adv();
      mi[0] = '0; mi[1] = '0;
      eval();
      chk("tp2_i_stall", i_bus.hready, 1'b0);
      chk("tp2_second", s_bus.haddr, 32'h200);
      adv();
      eval();
      chk("tp2_i_done", i_bus.hready, 1'b1);
      adv();

      // d write with three wait states while i requests
      mreq(1, 32'h40, 1'b1, 1'b0); wd[1] = 32'hdead_beef;
      eval();
      adv();
      mi[1] = '0; mreq(0, 32'h300, 1'b0, 1'b0); sh_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         eval();
         chk("tp3_hwdata", s_bus.hwdata, 32'hdead_beef);
         adv();
      end
      sh_ready = 1'b1;
      eval();
      chk("tp3_hwdata_last", s_bus.hwdata, 32'hdead_beef);
      chk("tp3_i_fwd", s_bus.haddr, 32'h300);
      adv();
      idle();
      eval();
      adv();

      // d locked sequence while i requests
      mreq(1, 32'h1000, 1'b0, 1'b1); mreq(0, 32'h2000, 1'b0, 1'b0);
      eval(); chk("tp4_d0", s_bus.haddr, 32'h1000); adv();
      mreq(1, 32'h1004, 1'b0, 1'b1);
      eval(); chk("tp4_d1", s_bus.haddr, 32'h1004); adv();
      mreq(1, 32'h1008, 1'b0, 1'b0);
      eval(); chk("tp4_d2", s_bus.haddr, 32'h1008); adv();
      mi[1] = '0;
      eval(); chk("tp4_i", s_bus.haddr, 32'h2000); adv();
      idle(); eval(); adv();

      // i lock overrides d priority
      mreq(0, 32'h3000, 1'b0, 1'b1);
      eval(); adv();
      mreq(0, 32'h3004, 1'b0, 1'b1); mreq(1, 32'h4000, 1'b0, 1'b0);
      eval(); chk("tp4b_i1", s_bus.haddr, 32'h3004); adv();
      mreq(0, 32'h3008, 1'b0, 1'b0);
      eval(); chk("tp4b_i2", s_bus.haddr, 32'h3008); adv();
      mi[0] = '0;
      eval(); chk("tp4b_d", s_bus.haddr, 32'h4000); adv();
      idle(); eval(); adv();

      // two-cycle error on i read, i cancels in first error cycle
      mreq(0, 32'h500, 1'b0, 1'b0);
      eval(); adv();
      mi[0] = '0; sh_ready = 1'b0; sh_resp = 1'b1;
      eval();
      chk("tp5_i_hresp0", i_bus.hresp, 1'b1);
      chk("tp5_d_hresp0", d_bus.hresp, 1'b0);
      adv();
      sh_ready = 1'b1;
      eval();
      chk("tp5_i_hresp1", i_bus.hresp, 1'b1);
      adv();
      sh_resp = 1'b0;
      eval();
      chk("tp5_no_buf", i_bus.hready, 1'b1);
      adv();

      // async reset with i buffered and d data phase pending
      mreq(1, 32'h600, 1'b1, 1'b0);
      eval(); adv();
      mi[1] = '0; mreq(0, 32'h700, 1'b0, 1'b0); sh_ready = 1'b0;
      eval(); adv();
      chk("tp6_pre_i_stall", i_bus.hready, 1'b0);
      rst_n = 1'b0;
      idle();
      drive();
      #1;
      chk("tp6_htrans", s_bus.htrans, HTRANS_IDLE);
      chk("tp6_i_hready", i_bus.hready, 1'b1);
      chk("tp6_d_hready", d_bus.hready, 1'b1);
      model_reset();
      rst_n = 1'b1;
      eval(); adv();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if (err == 1) begin
            sh_ready = 1'b1; sh_resp = 1'b1; err = 0;
         end else if (own != 0 && $urandom_range(0, 15) == 0) begin
            sh_ready = 1'b0; sh_resp = 1'b1; err = 1;
         end else begin
            sh_ready = $urandom_range(0, 3) != 0; sh_resp = 1'b0;
         end
         sh_exokay = 1'($urandom_range(0, 1));
         sh_rdata = $urandom;
         for (int m = 0; m < 2; m++) begin
            wd[m] = $urandom;
            if ((own == m + 1) ? sh_ready : (pq[m].size() == 0)) mi[m] = rnd_req();
         end
         eval();
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
